face_classifier_mac_pipe: RTL and testbench
===========================================

# face_classifier_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the face-classifier datapath. It generalises the single-cycle 12×12 truncating product to configurable operand, accumulator and output widths, a configurable multiplier pipeline depth and a fixed-point rescale stage with optional saturation. Valid/ready handshakes on input and output with backpressure let it stream dot products, one beat per cycle, directly from the feature and weight buffers.

## Interface
- DIN0_WIDTH, 12, signed operand A width
- DIN1_WIDTH, 12, signed operand B width
- ACC_WIDTH, 32, accumulator width; must be ≥ DIN0_WIDTH+DIN1_WIDTH
- DOUT_WIDTH, 12, result width
- FRAC_SHIFT, 0, arithmetic right shift applied to the final sum (0..ACC_WIDTH-1)
- NUM_STAGE, 3, multiplier pipeline registers (≥1)
- SAT_MODE, 1, 1 = saturate to DOUT_WIDTH, 0 = two's-complement wrap

- ap_clk  in  1  clock; all state on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- din0  in  DIN0_WIDTH  signed operand A
- din1  in  DIN1_WIDTH  signed operand B
- in_first  in  1  beat starts a new sum
- in_last  in  1  beat ends the current sum
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dout  out  DOUT_WIDTH  rescaled result
- dout_sat  out  1  saturation was applied to dout

## Operation
- Product: full-precision signed din0×din1 (DIN0_WIDTH+DIN1_WIDTH bits), sign-extended to ACC_WIDTH.
- Accumulate (product leaves the pipeline): acc_next = first ? prod : acc + prod; acc wraps modulo 2^ACC_WIDTH.
- in_first mid-sum discards the partial sum. in_last without prior in_first adds to the current acc (0 after reset). A first+last beat yields a single-product result.
- On last: acc cleared to 0; output register loads rescale(acc_next).
- Rescale: if FRAC_SHIFT>0, add 2^(FRAC_SHIFT-1) in ACC_WIDTH+1 bits, then arithmetic shift right by FRAC_SHIFT (round half toward +inf).
- Narrowing: SAT_MODE=1 clamps to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] and sets dout_sat when clamped; SAT_MODE=0 keeps the low DOUT_WIDTH bits and holds dout_sat=0.
- Output register holds dout/dout_sat/out_valid until out_valid && out_ready.

## Timing
- Reset values: in_ready=0 while ap_rst_n low, all pipeline valid bits 0, acc=0, out_valid=0, dout=0, dout_sat=0.
- Global enable en = !out_valid || out_ready. in_ready = en after reset. Every pipeline stage, acc and the output register advance only when en=1.
- Latency: a last beat accepted at edge k gives out_valid high after edge k+NUM_STAGE+1 (4 cycles by default).
- Throughput: one beat per cycle while out_ready=1. Back-to-back single-beat sums give back-to-back results.
- Simultaneous drain and load: with out_valid && out_ready and a new result arriving, the register reloads on the same edge and out_valid stays high.
- Bubbles: in_valid=0 beats advance as invalid stages and do not touch acc.
- Reset mid-operation: all partial sums and pending results are discarded immediately.

## Structure
- Package face_classifier_mac_pkg contains:
  - SAT_MODE_WRAP=0 and SAT_MODE_SAT=1
  - parameter-legality checks (ACC_WIDTH, FRAC_SHIFT, NUM_STAGE)
  - a pure saturate(value, width) function
- Sub-module face_classifier_mac_mul_pipe: NUM_STAGE-deep signed multiplier with enable, carrying valid/first/last sidebands; maps to DSP48.
- Top level holds the accumulator, rescale logic, output register and handshake.

## Test plan
- Defaults, single beat first+last, din0=-3, din1=5 -> dout=-15, dout_sat=0, out_valid 4 cycles after accept.
- Four beats of (100,100), SAT_MODE=1 -> dout=2047 with dout_sat=1; SAT_MODE=0 -> dout=-960 with dout_sat=0.
- FRAC_SHIFT=4, single beats 3×9 then -3×9 -> dout=2, then dout=-2.
- out_ready low for 10 cycles under a continuous stream -> in_ready drops once out_valid=1, dout held stable, no beat lost or duplicated (compare against scoreboard).
- ap_rst_n pulsed low after 2 of 4 beats, then single beat 2×2 -> only dout=4 appears, and the prior sum never emerges.
- Beats (1,1,first), (1,1), (2,3,first+last) -> dout=6.

Source files
------------

// File: rtl/face_classifier_mac_pkg.sv
// Shared constants, parameter legality helpers and saturation
// arithmetic for the face-classifier signed MAC pipeline.
package face_classifier_mac_pkg;

  localparam int SAT_MODE_WRAP = 0;
  localparam int SAT_MODE_SAT  = 1;
  localparam int MAX_WIDTH     = 63;

  function automatic bit acc_width_ok(
    input int acc_w,
    input int din0_w,
    input int din1_w
  );
    return (acc_w >= din0_w + din1_w) && (acc_w <= MAX_WIDTH);
  endfunction

  function automatic bit frac_shift_ok(
    input int frac,
    input int acc_w
  );
    return (frac >= 0) && (frac < acc_w);
  endfunction

  function automatic bit num_stage_ok(input int n);
    return n >= 1;
  endfunction

  function automatic bit dout_width_ok(
    input int dout_w,
    input int acc_w
  );
    return (dout_w >= 1) && (dout_w <= acc_w + 1);
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] value,
    input int                 width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/face_classifier_mac_mul_pipe.sv
// Signed multiplier with operand register plus NUM_STAGE product
// registers, carrying valid/first/last alongside; freezes when en=0.
module face_classifier_mac_mul_pipe #(
  parameter int A_W       = 12,
  parameter int B_W       = 12,
  parameter int NUM_STAGE = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               p_valid,
  output logic               p_first,
  output logic               p_last,
  output logic [A_W+B_W-1:0] prod
);
  import face_classifier_mac_pkg::*;

  localparam int P_W = A_W + B_W;

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic                  v_q;
  logic                  f_q;
  logic                  l_q;

  logic signed [P_W-1:0] p_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  pv_q;
  logic [NUM_STAGE-1:0]  pf_q;
  logic [NUM_STAGE-1:0]  pl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      v_q  <= 1'b0;
      f_q  <= 1'b0;
      l_q  <= 1'b0;
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        p_q[i] <= '0;
      end
    end else if (en) begin
      a_q     <= $signed(a);
      b_q     <= $signed(b);
      v_q     <= in_valid;
      f_q     <= in_first;
      l_q     <= in_last;
      p_q[0]  <= P_W'(a_q) * P_W'(b_q);
      pv_q[0] <= v_q;
      pf_q[0] <= f_q;
      pl_q[0] <= l_q;
      for (int i = 1; i < NUM_STAGE; i++) begin
        p_q[i]  <= p_q[i-1];
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  assign prod    = p_q[NUM_STAGE-1];
  assign p_valid = pv_q[NUM_STAGE-1];
  assign p_first = pf_q[NUM_STAGE-1];
  assign p_last  = pl_q[NUM_STAGE-1];

endmodule

// File: rtl/face_classifier_mac_pipe.sv
// Streaming signed MAC: pipelined product, wrapping accumulator,
// rounded rescale, optional saturation, valid/ready output register.
module face_classifier_mac_pipe
  import face_classifier_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 12,
  parameter int DIN1_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 12,
  parameter int FRAC_SHIFT = 0,
  parameter int NUM_STAGE  = 3,
  parameter int SAT_MODE   = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_sat
);

  localparam int P_W = DIN0_WIDTH + DIN1_WIDTH;
  localparam int S_W = ACC_WIDTH + 1;
  localparam int RS  = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [S_W-1:0] ROUND =
    (FRAC_SHIFT > 0) ? (S_W'(1) <<< RS) : '0;

  if (!acc_width_ok(ACC_WIDTH, DIN0_WIDTH, DIN1_WIDTH))
  begin : g_bad_acc
    $error("ACC_WIDTH too small or too large");
  end
  if (!frac_shift_ok(FRAC_SHIFT, ACC_WIDTH)) begin : g_bad_frac
    $error("FRAC_SHIFT out of range");
  end
  if (!num_stage_ok(NUM_STAGE)) begin : g_bad_stage
    $error("NUM_STAGE must be at least 1");
  end
  if (!dout_width_ok(DOUT_WIDTH, ACC_WIDTH)) begin : g_bad_dout
    $error("DOUT_WIDTH out of range");
  end

  logic           en;
  logic           p_valid;
  logic           p_first;
  logic           p_last;
  logic [P_W-1:0] prod;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [S_W-1:0]       rounded;
  logic signed [S_W-1:0]       scaled;
  logic signed [63:0]          wide;
  logic signed [63:0]          clamped;
  logic [DOUT_WIDTH-1:0]       dout_next;
  logic                        sat_next;

  // A stalled output register freezes the whole pipe.
  assign en       = !out_valid || out_ready;
  assign in_ready = ap_rst_n && en;

  face_classifier_mac_mul_pipe #(
    .A_W       (DIN0_WIDTH),
    .B_W       (DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .a        (din0),
    .b        (din1),
    .p_valid  (p_valid),
    .p_first  (p_first),
    .p_last   (p_last),
    .prod     (prod)
  );

  assign prod_ext = ACC_WIDTH'($signed(prod));
  assign acc_next = p_first ? prod_ext : acc + prod_ext;
  assign rounded  = S_W'(acc_next) + ROUND;
  assign scaled   = rounded >>> FRAC_SHIFT;
  assign wide     = 64'(scaled);
  assign clamped  = saturate(wide, DOUT_WIDTH);

  always_comb begin
    dout_next = scaled[DOUT_WIDTH-1:0];
    sat_next  = 1'b0;
    if (SAT_MODE == SAT_MODE_SAT) begin
      dout_next = clamped[DOUT_WIDTH-1:0];
      sat_next  = clamped != wide;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      dout_sat  <= 1'b0;
    end else if (en) begin
      if (p_valid) begin
        acc <= p_last ? '0 : acc_next;
      end
      out_valid <= p_valid && p_last;
      if (p_valid && p_last) begin
        dout     <= dout_next;
        dout_sat <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_face_classifier_mac_pipe.sv
// Scoreboard bench: three configurations (saturate, wrap, shift-by-4)
// share one stimulus stream; a monitor pops expectations on transfer.
module tb_face_classifier_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  dout_sat;
  logic [11:0] dout [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d0; int s0;
    int d1; int s1;
    int d2; int s2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  face_classifier_mac_pipe u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .din0(din0), .din1(din1),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .dout(dout[0]), .dout_sat(dout_sat[0])
  );

  face_classifier_mac_pipe #(.SAT_MODE(0)) u_wrap (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .din0(din0), .din1(din1),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .dout(dout[1]), .dout_sat(dout_sat[1])
  );

  face_classifier_mac_pipe #(.FRAC_SHIFT(4)) u_frac (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready[2]),
    .din0(din0), .din1(din1),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .dout(dout[2]), .dout_sat(dout_sat[2])
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int d0, int s0, int d1, int s1,
                      int d2, int s2);
    exp_t e;
    e.d0 = d0; e.s0 = s0;
    e.d1 = d1; e.s1 = s1;
    e.d2 = d2; e.s2 = s2;
    sb.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int a, int b, bit f, bit l);
    bit ok;
    int n;
    in_valid = 1'b1;
    din0     = 12'(a);
    din1     = 12'(b);
    in_first = f;
    in_last  = l;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready[0];
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(1);
    chk(name, sb.size(), 0);
  endtask

  // Scoreboard monitor: compares whenever a result transfers.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid[0] && out_ready) begin
      chk("valid_align", int'(out_valid), 7);
      if (sb.size() == 0) begin
        chk("unexpected_result", $signed(dout[0]), 99999);
      end else begin
        e = sb.pop_front();
        chk("dout_sat_cfg", $signed(dout[0]), e.d0);
        chk("flag_sat_cfg", int'(dout_sat[0]), e.s0);
        chk("dout_wrap_cfg", $signed(dout[1]), e.d1);
        chk("flag_wrap_cfg", int'(dout_sat[1]), e.s1);
        chk("dout_frac_cfg", $signed(dout[2]), e.d2);
        chk("flag_frac_cfg", int'(dout_sat[2]), e.s2);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int fr [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    logic [11:0] held;
    bit held_set;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dout", int'(dout[0]), 0);
    chk("rst_dout_sat", int'(dout_sat), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // single beat, latency
    push(-15, 0, -15, 0, -1, 0);
    send(-3, 5, 1, 1);
    idle(3);
    chk("latency_early", int'(out_valid[0]), 0);
    idle(1);
    chk("latency_on_time", int'(out_valid[0]), 1);

    // four beats with bubbles
    push(2047, 1, -960, 0, 2047, 1);
    send(100, 100, 1, 0);
    idle(1);
    send(100, 100, 0, 0);
    send(100, 100, 0, 0);
    idle(2);
    send(100, 100, 0, 1);

    // back-to-back single beats, rounding
    push(27, 0, 27, 0, 2, 0);
    send(3, 9, 1, 1);
    push(-27, 0, -27, 0, -2, 0);
    send(-3, 9, 1, 1);

    // first mid-sum discards partial
    push(6, 0, 6, 0, 0, 0);
    send(1, 1, 1, 0);
    send(1, 1, 0, 0);
    send(2, 3, 1, 1);

    // extremes
    push(-2048, 1, -2048, 0, -2048, 1);
    send(-2048, 2047, 1, 1);
    push(2047, 1, 0, 0, 2047, 1);
    send(-2048, -2048, 1, 1);
    drain("drain_basic");

    // backpressure under a continuous stream
    out_ready = 1'b0;
    held_set  = 1'b0;
    held      = '0;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          push(2 * i, 0, 2 * i, 0, fr[i-1], 0);
          send(i, 2, 1, 1);
        end
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (out_valid[0]) begin
            if (!held_set) begin
              held     = dout[0];
              held_set = 1'b1;
            end
            chk("stall_in_ready", int'(in_ready[0]), 0);
            chk("stall_dout_held", int'(dout[0]), int'(held));
          end
        end
        chk("stall_saw_valid", int'(held_set), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // reset mid-sum
    send(50, 50, 1, 0);
    send(50, 50, 0, 0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    push(4, 0, 4, 0, 0, 0);
    send(2, 2, 0, 1);
    push(25, 0, 25, 0, 2, 0);
    send(5, 5, 0, 1);
    drain("drain_reset");

    idle(8);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
